// File: rtl/mips_cpu_instr_rom_loader.sv
// Instruction ROM for the Harvard MIPS core: filled once from a byte-serial
// valid/ready stream, then answers combinational instruction fetches.
module mips_cpu_instr_rom_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          DEPTH_WORDS = 64,
    parameter int          IDX_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [7:0]       load_byte,
    input  logic             load_last,
    output logic             loaded,
    output logic             load_overflow,
    output logic [IDX_W:0]   words_loaded,
    input  logic [31:0]      instr_address,
    output logic [31:0]      instr_readdata,
    output logic             fetch_fault
);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        lane;
    logic [31:0]       asm_word;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              accept;
    logic              full;
    logic [31:0]       word_now;
    logic [IDX_W-1:0]  wr_idx;
    logic [31:0]       fetch_off;
    logic [IDX_W-1:0]  fetch_idx;
    logic              fetch_in_range;
    logic              fetch_aligned;

    // Place a byte into its little-endian lane of the word being assembled.
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [7:0]  data,
                                               input logic [1:0]  sel);
        logic [31:0] shifted;
        shifted = {24'd0, data} << {sel, 3'b000};
        return word | shifted;
    endfunction

    assign accept   = load_valid & load_ready;
    assign full     = (words_loaded == (IDX_W+1)'(DEPTH_WORDS));
    assign word_now = merge_lane(asm_word, load_byte, lane);
    assign wr_idx   = words_loaded[IDX_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        loaded     = 1'b0;
        case (state)
            S_LOAD: begin
                load_ready = 1'b1;
                if (accept && load_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                loaded = 1'b1;
            end
            default: state_next = S_LOAD;
        endcase
    end

    // Bytes past the last word are dropped; only the sticky flag records them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane          <= 2'd0;
            asm_word      <= 32'd0;
            words_loaded  <= '0;
            load_overflow <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (accept) begin
            if (full) begin
                load_overflow <= 1'b1;
            end else if (lane == 2'd3 || load_last) begin
                mem[wr_idx]  <= word_now;
                words_loaded <= words_loaded + (IDX_W+1)'(1);
                lane         <= 2'd0;
                asm_word     <= 32'd0;
            end else begin
                asm_word <= word_now;
                lane     <= lane + 2'd1;
            end
        end
    end

    assign fetch_off      = instr_address - BASE_ADDR;
    assign fetch_idx      = fetch_off[IDX_W+1:2];
    assign fetch_in_range = (fetch_off < 32'(4 * DEPTH_WORDS));
    assign fetch_aligned  = (instr_address[1:0] == 2'b00);

    // Address 0 is the CPU halt target and must never fault.
    always_comb begin
        instr_readdata = 32'd0;
        fetch_fault    = 1'b0;
        if (instr_address != 32'd0) begin
            if (!fetch_aligned || !fetch_in_range) begin
                fetch_fault = 1'b1;
            end else if (loaded) begin
                instr_readdata = mem[fetch_idx];
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_instr_rom_loader.sv
// Bench for the instruction ROM loader: streams images, then fetches every
// word and compares against expectations derived from the byte image.
module tb_mips_cpu_instr_rom_loader;

    localparam logic [31:0] BASE = 32'hBFC00000;
    localparam int          DEPTH = 64;
    localparam int          IDXW  = 6;

    logic            clk;
    logic            reset;
    logic            load_valid;
    logic            load_ready;
    logic [7:0]      load_byte;
    logic            load_last;
    logic            loaded;
    logic            load_overflow;
    logic [IDXW:0]   words_loaded;
    logic [31:0]     instr_address;
    logic [31:0]     instr_readdata;
    logic            fetch_fault;

    mips_cpu_instr_rom_loader #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .IDX_W       (IDXW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_byte      (load_byte),
        .load_last      (load_last),
        .loaded         (loaded),
        .load_overflow  (load_overflow),
        .words_loaded   (words_loaded),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .fetch_fault    (fetch_fault)
    );

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  img[$];
    int          n_checks = 0;
    int          n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        load_valid = 1'b0;
        load_last = 1'b0;
        load_byte = 8'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Drive img[] as one stream; optionally idle one cycle before each byte.
    task automatic stream(input bit gaps, input bit with_last, input int count);
        for (int i = 0; i < count; i++) begin
            if (gaps) begin
                load_valid = 1'b0;
                load_byte  = 8'($urandom);
                load_last  = 1'($urandom);
                @(posedge clk);
                #1;
            end
            load_valid = 1'b1;
            load_byte  = img[i];
            load_last  = with_last && (i == count - 1);
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Expected array contents derived directly from the byte image.
    task automatic push_image_expect(input string tag, input int nwords_fetch);
        for (int w = 0; w < nwords_fetch; w++) begin
            exp_t e;
            logic [31:0] word;
            word = 32'd0;
            for (int b = 0; b < 4; b++) begin
                int k;
                k = 4 * w + b;
                if (k < img.size() && k < 4 * DEPTH) word[8*b +: 8] = img[k];
            end
            e.tag = $sformatf("%s_w%0d", tag, w);
            e.addr = BASE + 32'(4 * w);
            e.data = word;
            e.fault = 1'b0;
            sbq.push_back(e);
        end
    endtask

    task automatic push_fetch(input string tag, input logic [31:0] a,
                              input logic [31:0] d, input logic f);
        exp_t e;
        e.tag = tag; e.addr = a; e.data = d; e.fault = f;
        sbq.push_back(e);
    endtask

    task automatic drain();
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            instr_address = e.addr;
            #2;
            chk({e.tag, "_data"}, instr_readdata, e.data);
            chk({e.tag, "_fault"}, 32'(fetch_fault), 32'(e.fault));
        end
    endtask

    task automatic chk_status(input string tag, input int words, input bit ovf, input bit ld);
        chk({tag, "_words"}, 32'(words_loaded), 32'(words));
        chk({tag, "_ovf"}, 32'(load_overflow), 32'(ovf));
        chk({tag, "_loaded"}, 32'(loaded), 32'(ld));
        chk({tag, "_ready"}, 32'(load_ready), 32'(!ld));
    endtask

    initial begin
        instr_address = BASE;
        do_reset();
        chk_status("rst", 0, 0, 0);
        push_fetch("nop_before_load", BASE, 32'd0, 1'b0);
        drain();

        // Program image, five words, LSB first
        img.delete();
        begin
            logic [31:0] prog[5];
            prog = '{32'h24840000, 32'h24A5004D, 32'h00A4102A, 32'h00000008, 32'h24000000};
            foreach (prog[w]) for (int b = 0; b < 4; b++) img.push_back(prog[w][8*b +: 8]);
        end
        stream(1'b0, 1'b1, img.size());
        chk_status("prog", 5, 0, 1);
        push_fetch("prog_fetch8", 32'hBFC00008, 32'h00A4102A, 1'b0);
        push_fetch("prog_fetch14", 32'hBFC00014, 32'd0, 1'b0);
        push_image_expect("prog", 6);
        push_fetch("misaligned", 32'hBFC00002, 32'd0, 1'b1);
        push_fetch("below_base", 32'hBFBFFFFC, 32'd0, 1'b1);
        push_fetch("past_end", 32'hBFC00100, 32'd0, 1'b1);
        push_fetch("halt_addr", 32'h00000000, 32'd0, 1'b0);
        drain();

        // Partial final word is zero-padded
        do_reset();
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        stream(1'b0, 1'b1, img.size());
        chk_status("partial", 2, 0, 1);
        push_fetch("partial_w0", BASE, 32'h44332211, 1'b0);
        push_fetch("partial_w1", BASE + 4, 32'h00006655, 1'b0);
        push_fetch("partial_w2", BASE + 8, 32'd0, 1'b0);
        drain();

        // Overflow: 4*64+4 bytes
        do_reset();
        img.delete();
        for (int i = 0; i < 4 * DEPTH + 4; i++) img.push_back(8'($urandom));
        stream(1'b0, 1'b1, img.size());
        chk_status("ovf", DEPTH, 1, 1);
        push_image_expect("ovf", DEPTH);
        drain();

        // Gapped stream matches a gap-free load of the same image
        do_reset();
        img.delete();
        for (int i = 0; i < 22; i++) img.push_back(8'($urandom));
        stream(1'b1, 1'b1, img.size());
        chk_status("gaps", 6, 0, 1);
        push_image_expect("gaps", 7);
        drain();

        // Async reset mid-load discards the partial image
        do_reset();
        img.delete();
        for (int i = 0; i < 7; i++) img.push_back(8'($urandom));
        stream(1'b0, 1'b0, img.size());
        chk("midload_words_pre", 32'(words_loaded), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midload_words_async", 32'(words_loaded), 32'd0);
        chk("midload_ovf_async", 32'(load_overflow), 32'd0);
        chk("midload_loaded_async", 32'(loaded), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        stream(1'b0, 1'b1, img.size());
        chk_status("reload", 1, 0, 1);
        push_fetch("reload_w0", BASE, 32'hDDCCBBAA, 1'b0);
        push_fetch("reload_w1", BASE + 4, 32'd0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
